dual_issue_fetch_queue: RTL and testbench

// - Instruction buffer directly upstream of the dual-issue decoder; accepts one fetched word per cycle from icache.
// - Presents the two oldest entries as an ordered pair, instr_o[0] older, to the decoder each cycle.
// - Retires 0, 1 or 2 entries per cycle as told by issue control; single-issue steps consume 1, dual-issue consumes 2.
// - Flushed on PC redirect (branch, jump, mret, interrupt).

---
 rtl/dual_issue_fetch_queue_pkg.sv | 16 +
 rtl/dual_issue_fetch_queue_mem.sv | 27 ++
 rtl/dual_issue_fetch_queue.sv | 110 +++++++++++
 tb/tb_dual_issue_fetch_queue.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dual_issue_fetch_queue_pkg.sv
// Shared types and constants for the dual-issue fetch queue.
package dual_issue_fetch_queue_pkg;

  typedef logic [31:0] instruction_s;

  localparam int unsigned pc_width_c = 22;

  typedef struct packed {
    instruction_s            instr;
    logic [pc_width_c-1:0]   pc;
  } fetch_entry_s;

  // addi x0, x0, 0: decodes with no rd/fp/branch side effects
  localparam instruction_s vanilla_nop_c = 32'h0000_0013;

endpackage

// File: rtl/dual_issue_fetch_queue_mem.sv
// Register file for the fetch queue: one write port, two asynchronous read ports.
module dual_issue_fetch_queue_mem #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 54
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr0_i,
  input  logic [$clog2(Depth)-1:0] raddr1_i,
  output logic [Width-1:0]         rdata0_o,
  output logic [Width-1:0]         rdata1_o
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = r_mem[raddr0_i];
  assign rdata1_o = r_mem[raddr1_i];

endmodule

// File: rtl/dual_issue_fetch_queue.sv
// Fetch buffer feeding the dual-issue decoder; presents the two oldest entries as a pair.
// Optional same-cycle bypass of an empty queue: define DUAL_ISSUE_FETCH_QUEUE_BYPASS_EN.
module dual_issue_fetch_queue
  import dual_issue_fetch_queue_pkg::*;
#(
  parameter int unsigned els_p      = 8,
  parameter int unsigned pc_width_p = 22
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             v_i,
  input  instruction_s                     instr_i,
  input  logic [pc_width_p-1:0]            pc_i,
  output logic                             ready_o,
  input  logic                             flush_i,
  output instruction_s [1:0]               instr_o,
  output logic [1:0][pc_width_p-1:0]       pc_o,
  output logic [1:0]                       v_o,
  input  logic [1:0]                       deq_cnt_i,
  output logic [$clog2(els_p+1)-1:0]       count_o
);

  localparam int unsigned PtrW   = $clog2(els_p);
  localparam int unsigned CntW   = $clog2(els_p + 1);
  localparam int unsigned EntryW = 32 + pc_width_p;
  localparam logic [CntW-1:0] Full = CntW'(els_p);

  logic [PtrW-1:0]       r_rd_ptr, r_wr_ptr;
  logic [CntW-1:0]       r_count;
  logic [EntryW-1:0]     w_rd0, w_rd1;
  logic [pc_width_p-1:0] w_pc0, w_pc1, w_pc0_next;
  logic                  w_push, w_we, w_v0, w_v1, w_bypass;
  logic [1:0]            w_avail, w_deq, w_deq_mem;

  dual_issue_fetch_queue_mem #(
    .Depth (els_p),
    .Width (EntryW)
  ) u_mem (
    .clk_i    (clk_i),
    .we_i     (w_we),
    .waddr_i  (r_wr_ptr),
    .wdata_i  ({instr_i, pc_i}),
    .raddr0_i (r_rd_ptr),
    .raddr1_i (r_rd_ptr + PtrW'(1)),
    .rdata0_o (w_rd0),
    .rdata1_o (w_rd1)
  );

  assign w_pc0      = w_rd0[pc_width_p-1:0];
  assign w_pc1      = w_rd1[pc_width_p-1:0];
  assign w_pc0_next = w_pc0 + pc_width_p'(1);

  always_comb begin
    ready_o = (r_count < Full);
    w_push  = v_i & ready_o;
    w_v0    = (r_count != '0);
    w_v1    = (r_count >= CntW'(2)) && (w_pc1 == w_pc0_next);
`ifdef DUAL_ISSUE_FETCH_QUEUE_BYPASS_EN
    w_bypass = w_push & (r_count == '0) & ~flush_i & ~reset_i;
`else
    w_bypass = 1'b0;
`endif
    v_o     = w_bypass ? 2'b01 : {w_v1, w_v0};
    w_avail = {1'b0, v_o[0]} + {1'b0, v_o[1]};
    w_deq   = (deq_cnt_i > w_avail) ? w_avail : deq_cnt_i;
    // A bypassed word retired in its arrival cycle never touches storage
    w_we      = w_push & ~flush_i & ~(w_bypass & (w_deq != 2'd0));
    w_deq_mem = w_bypass ? 2'd0 : w_deq;

    instr_o[0] = vanilla_nop_c;
    instr_o[1] = vanilla_nop_c;
    pc_o[0]    = '0;
    pc_o[1]    = '0;
    if (w_bypass) begin
      instr_o[0] = instr_i;
      pc_o[0]    = pc_i;
    end else begin
      if (v_o[0]) begin
        instr_o[0] = w_rd0[EntryW-1:pc_width_p];
        pc_o[0]    = w_pc0;
      end
      if (v_o[1]) begin
        instr_o[1] = w_rd1[EntryW-1:pc_width_p];
        pc_o[1]    = w_pc1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PtrW'(w_deq_mem);
      r_wr_ptr <= r_wr_ptr + PtrW'(w_we);
      r_count  <= r_count + CntW'(w_we) - CntW'(w_deq_mem);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && !flush_i) begin
      assert (deq_cnt_i <= w_avail)
        else $error("deq_cnt_i %0d exceeds valid slots %0d", deq_cnt_i, w_avail);
    end
  end

  assign count_o = r_count;

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// Randomized bench for dual_issue_fetch_queue with a queue-based reference model.
module tb_dual_issue_fetch_queue;

  localparam int Els = 8;
  localparam int PcW = 22;

  typedef struct {
    logic [31:0]    instr;
    logic [PcW-1:0] pc;
  } ent_t;

  logic                 clk = 1'b0;
  logic                 reset_i, v_i, flush_i, ready_o;
  logic [31:0]          instr_i;
  logic [PcW-1:0]       pc_i;
  logic [1:0][31:0]     instr_o;
  logic [1:0][PcW-1:0]  pc_o;
  logic [1:0]           v_o, deq_cnt_i;
  logic [3:0]           count_o;

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  bit   model_valid = 0;
  bit   cur_byp;
  logic [1:0] cur_ev;
  int   cur_pop;
  logic [PcW-1:0] last_pc = '0;

  dual_issue_fetch_queue #(
    .els_p      (Els),
    .pc_width_p (PcW)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .v_i       (v_i),
    .instr_i   (instr_i),
    .pc_i      (pc_i),
    .ready_o   (ready_o),
    .flush_i   (flush_i),
    .instr_o   (instr_o),
    .pc_o      (pc_o),
    .v_o       (v_o),
    .deq_cnt_i (deq_cnt_i),
    .count_o   (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected slot validity from the queue contents and current inputs
  task automatic calc();
    logic [PcW-1:0] nxt;
    cur_byp = 0;
`ifdef DUAL_ISSUE_FETCH_QUEUE_BYPASS_EN
    cur_byp = (q.size() == 0) && v_i && !flush_i && !reset_i;
`endif
    cur_ev = 2'b00;
    if (cur_byp) cur_ev = 2'b01;
    else begin
      if (q.size() >= 1) cur_ev[0] = 1'b1;
      if (q.size() >= 2) begin
        nxt = q[0].pc + PcW'(1);
        cur_ev[1] = (q[1].pc == nxt);
      end
    end
    cur_pop = int'(cur_ev[0]) + int'(cur_ev[1]);
  endtask

  task automatic compare();
    logic [31:0]    ei0, ei1;
    logic [PcW-1:0] ep0, ep1;
    ei0 = 32'h13; ei1 = 32'h13; ep0 = '0; ep1 = '0;
    if (cur_byp) begin
      ei0 = instr_i; ep0 = pc_i;
    end else begin
      if (cur_ev[0]) begin ei0 = q[0].instr; ep0 = q[0].pc; end
      if (cur_ev[1]) begin ei1 = q[1].instr; ep1 = q[1].pc; end
    end
    chk("count_o", 32'(count_o), 32'(q.size()));
    chk("ready_o", 32'(ready_o), 32'(q.size() < Els));
    chk("v_o", 32'(v_o), 32'(cur_ev));
    chk("instr_o0", instr_o[0], ei0);
    chk("instr_o1", instr_o[1], ei1);
    chk("pc_o0", 32'(pc_o[0]), 32'(ep0));
    chk("pc_o1", 32'(pc_o[1]), 32'(ep1));
  endtask

  task automatic update();
    int  d;
    bit  push;
    if (reset_i || flush_i) begin
      q.delete();
    end else begin
      push = v_i && (q.size() < Els);
      d = (int'(deq_cnt_i) > cur_pop) ? cur_pop : int'(deq_cnt_i);
      if (!(cur_byp && d == 1)) begin
        repeat (d) void'(q.pop_front());
        if (push) q.push_back('{instr: instr_i, pc: pc_i});
      end
    end
  endtask

  // deq < 0 picks a random legal retire count
  task automatic step(bit rst, bit v, logic [31:0] ins, logic [PcW-1:0] pc, bit fl, int deq);
    @(negedge clk);
    reset_i = rst; v_i = v; instr_i = ins; pc_i = pc; flush_i = fl;
    calc();
    if (deq < 0) deq_cnt_i = 2'($urandom_range(0, cur_pop));
    else         deq_cnt_i = 2'(deq);
    #1;
    if (model_valid) compare();
    @(posedge clk);
    update();
    if (rst) model_valid = 1;
    #1;
    reset_i = 0; v_i = 0; flush_i = 0; deq_cnt_i = '0;
    #1;
  endtask

  task automatic push(logic [PcW-1:0] pc);
    step(0, 1, $urandom, pc, 0, 0);
  endtask

  task automatic deq(int n);
    step(0, 0, 32'h0, '0, 0, n);
  endtask

  initial begin
    reset_i = 1; v_i = 0; flush_i = 0; deq_cnt_i = '0; instr_i = '0; pc_i = '0;

    step(1, 0, 32'h0, '0, 0, 0);
    step(1, 1, 32'h1234, 22'h5, 0, 0);
    chk("rst_v_o", 32'(v_o), 32'h0);
    chk("rst_instr0", instr_o[0], 32'h13);
    chk("rst_instr1", instr_o[1], 32'h13);
    chk("rst_ready", 32'(ready_o), 32'h1);
    chk("rst_count", 32'(count_o), 32'h0);
    chk("rst_pc0", 32'(pc_o[0]), 32'h0);

    push(22'h10); push(22'h11); push(22'h12);
    chk("seq_count", 32'(count_o), 32'd3);
    chk("seq_v_o", 32'(v_o), 32'h3);
    chk("seq_pc0", 32'(pc_o[0]), 32'h10);
    chk("seq_pc1", 32'(pc_o[1]), 32'h11);
    deq(2);
    chk("deq2_pc0", 32'(pc_o[0]), 32'h12);
    chk("deq2_v_o", 32'(v_o), 32'h1);

    step(0, 0, 32'h0, '0, 1, 0);
    push(22'h20); push(22'h40);
    chk("nonseq_v_o", 32'(v_o), 32'h1);
    deq(1);
    chk("nonseq_pc0", 32'(pc_o[0]), 32'h40);

    step(0, 0, 32'h0, '0, 1, 0);
    for (int i = 0; i < 6; i++) push(PcW'(32'h100 + i));
    for (int i = 0; i < 3; i++) deq(2);
    for (int i = 0; i < 8; i++) push(PcW'(32'h200 + i));
    chk("full_count", 32'(count_o), 32'd8);
    chk("full_ready", 32'(ready_o), 32'h0);
    step(0, 1, $urandom, 22'h3ff, 0, 0);
    chk("full_drop", 32'(count_o), 32'd8);
    step(0, 1, $urandom, 22'h300, 0, 2);
    chk("full_deq_count", 32'(count_o), 32'd6);
    chk("full_deq_pc0", 32'(pc_o[0]), 32'h202);
    push(22'h208);
    for (int i = 0; i < 3; i++) deq(2);
    chk("wrap_pc0", 32'(pc_o[0]), 32'h208);
    chk("wrap_count", 32'(count_o), 32'd1);

    for (int i = 0; i < 4; i++) push(PcW'(32'h209 + i));
    chk("pre_flush_count", 32'(count_o), 32'd5);
    step(0, 1, $urandom, 22'h555, 1, 2);
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_v_o", 32'(v_o), 32'h0);
    push(22'h80);
    chk("post_flush_pc0", 32'(pc_o[0]), 32'h80);
    chk("post_flush_v_o", 32'(v_o), 32'h1);

    // Empty queue: exercises bypass when enabled, plain one-cycle latency otherwise
    step(0, 0, 32'h0, '0, 1, 0);
    step(0, 1, 32'hdead_beef, 22'h30, 0, -1);

    for (int i = 0; i < 3000; i++) begin
      bit rst, fl, v;
      logic [PcW-1:0] pc;
      rst = ($urandom_range(0, 199) == 0);
      fl  = ($urandom_range(0, 23) == 0);
      v   = ($urandom_range(0, 3) != 0);
      pc  = ($urandom_range(0, 4) == 0) ? PcW'($urandom) : last_pc + PcW'(1);
      if (v) last_pc = pc;
      step(rst, v, $urandom, pc, fl, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
